data_mem_responder: RTL and testbench

Multi-cycle data-memory responder: the memory side of the CPU's data-memory request interface. It accepts one read or write request at a time through a valid/ready handshake and answers after a fixed latency. Reads can optionally return a critical-word-first burst for cache-line fills. It replaces the single-cycle data memory when the pipeline and cache are built, and it serves as the bench model of the slow main memory.

---
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: one request at a time, single beats or
// critical-word-first wrapping bursts, backed by an inferred 16-bit word RAM.
module data_mem_responder #(
   parameter int LATENCY   = 4,
   parameter int BURST_LEN = 8,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic              req_burst,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   output logic [15:0]       resp_rdata,
   output logic              resp_last
);

   localparam int WA    = ADDR_W - 1;
   localparam int OFF_W = $clog2(BURST_LEN);
   localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [OFF_W-1:0]  beat_q, beat_d;
   logic              wr_q, wr_d;
   logic              burst_q, burst_d;
   logic [WA-1:0]     addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_last_q, resp_last_d;

   logic              mem_we;
   logic [WA-1:0]     mem_waddr;
   logic [15:0]       mem_wdata;
   logic [WA-1:0]     mem_raddr;
   logic [OFF_W-1:0]  burst_off;
   logic [15:0]       rdata_q;
   logic [15:0]       mem_q [2**WA];
   logic              addr_lsb_unused;

   assign addr_lsb_unused = req_addr[0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      beat_d       = beat_q;
      wr_d         = wr_q;
      burst_d      = burst_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_last_d  = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = addr_q;
      mem_wdata    = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               burst_d = req_burst & ~req_wr;
               addr_d  = req_addr[ADDR_W-1:1];
               wdata_d = req_wdata;
               beat_d  = '0;
               cnt_d   = CNT_INIT;
               if (LATENCY == 1) begin
                  // No WAIT phase, so the write commits straight from the request bus.
                  state_d   = RESP;
                  mem_we    = req_wr;
                  mem_waddr = req_addr[ADDR_W-1:1];
                  mem_wdata = req_wdata;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               mem_we  = wr_q;
            end
         end
         RESP: begin
            // Stay one extra cycle so req_ready only rises after the last beat is seen.
            if (resp_last_q) begin
               state_d = IDLE;
            end else begin
               resp_valid_d = 1'b1;
               resp_last_d  = ~burst_q | (beat_q == LAST_BEAT);
               beat_d       = beat_q + OFF_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         beat_q       <= '0;
         wr_q         <= 1'b0;
         burst_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         beat_q       <= beat_d;
         wr_q         <= wr_d;
         burst_q      <= burst_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_last_q  <= resp_last_d;
      end
   end

   // Burst offset wraps inside the aligned block; upper word bits stay fixed.
   assign burst_off = addr_q[OFF_W-1:0] + beat_q;
   assign mem_raddr = burst_q ? {addr_q[WA-1:OFF_W], burst_off} : addr_q;

   always_ff @(posedge clk) begin
      if (mem_we && rst) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
      rdata_q <= mem_q[mem_raddr];
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_last  = resp_last_q;
   assign resp_rdata = (resp_valid_q && !wr_q) ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: latency, burst wrap, reset drop,
// handshake hold and burst-write handling, all against hand-computed values.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic        req_burst;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_last;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] beats [8];
   logic        lasts [8];
   int          n_beats;
   int          lat;
   int          last_k;
   logic        ready_at_last;
   logic        ready_after;
   logic        valid_after;

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(4), .BURST_LEN(8), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_burst  (req_burst),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_last  (resp_last)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request and collect its beats; returns at the negedge after the last beat.
   task automatic xact(input logic wr, input logic burst, input logic [15:0] addr,
                       input logic [15:0] wdata);
      int  guard;
      logic done;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_burst = burst;
      req_addr  = addr;
      req_wdata = wdata;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check_eq("ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n_beats = 0;
      lat = -1;
      last_k = -1;
      ready_at_last = 1'bx;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (resp_valid) begin
            if (n_beats == 0) lat = k;
            if (n_beats < 8) begin
               beats[n_beats] = resp_rdata;
               lasts[n_beats] = resp_last;
            end
            n_beats++;
            if (resp_last || n_beats >= 8) begin
               done = 1'b1;
               last_k = k;
               ready_at_last = req_ready;
            end
         end
         if (!done) @(negedge clk);
      end
      if (!done) check_eq("resp_timeout", 32'(done), 32'd1);
      @(negedge clk);
      ready_after = req_ready;
      valid_after = resp_valid;
      $display("xact wr=%0b burst=%0b addr=0x%04h wdata=0x%04h beats=%0d lat=%0d first=0x%04h",
               wr, burst, addr, wdata, n_beats, lat, beats[0]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepts;
      int hold_beats;
      int ready_when_last;
      int reset_beats;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_burst = 1'b0;
      req_addr  = 16'h0;
      req_wdata = 16'h0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(req_ready), 32'd1);
      check_eq("rst_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_rdata", 32'(resp_rdata), 32'd0);
      check_eq("rst_last", 32'(resp_last), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a write's WAIT must drop the write.
      xact(1'b1, 1'b0, 16'h0010, 16'h1111);
      check_eq("pre_wr_beats", 32'(n_beats), 32'd1);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_burst = 1'b0;
      req_addr  = 16'h0010;
      req_wdata = 16'h9999;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("mid_wait_busy", 32'(req_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_ready", 32'(req_ready), 32'd1);
      check_eq("async_rst_valid", 32'(resp_valid), 32'd0);
      reset_beats = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) reset_beats++;
      end
      check_eq("beats_in_reset", 32'(reset_beats), 32'd0);
      rst = 1'b1;
      xact(1'b0, 1'b0, 16'h0010, 16'h0000);
      check_eq("dropped_write_data", 32'(beats[0]), 32'h1111);

      // Write then read with latency and handshake checks.
      xact(1'b1, 1'b0, 16'h0024, 16'hBEEF);
      check_eq("wr_lat", 32'(lat), 32'd4);
      check_eq("wr_beats", 32'(n_beats), 32'd1);
      check_eq("wr_ack_rdata", 32'(beats[0]), 32'd0);
      check_eq("wr_ack_last", 32'(lasts[0]), 32'd1);
      check_eq("ready_at_last", 32'(ready_at_last), 32'd0);
      check_eq("ready_after_last", 32'(ready_after), 32'd1);
      check_eq("valid_after_last", 32'(valid_after), 32'd0);
      xact(1'b0, 1'b0, 16'h0024, 16'h0000);
      check_eq("rd_lat", 32'(lat), 32'd4);
      check_eq("rd_data", 32'(beats[0]), 32'hBEEF);
      check_eq("rd_last", 32'(lasts[0]), 32'd1);

      // Critical-word-first burst within the aligned block.
      for (int i = 0; i < 8; i++) xact(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'(16'hA000 + i));
      xact(1'b0, 1'b1, 16'h0046, 16'h0000);
      check_eq("burst_beats", 32'(n_beats), 32'd8);
      check_eq("burst_lat", 32'(lat), 32'd4);
      check_eq("burst_no_gaps", 32'(last_k - lat), 32'd7);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("burst_data_%0d", i), 32'(beats[i]), 32'(16'hA000 + ((i + 3) % 8)));
         check_eq($sformatf("burst_last_%0d", i), 32'(lasts[i]), 32'(i == 7));
      end

      // req_valid held high: one acceptance per IDLE cycle, one beat per request.
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_burst = 1'b0;
      req_addr  = 16'h0024;
      accepts = 0;
      hold_beats = 0;
      ready_when_last = 0;
      for (int i = 0; i < 23; i++) begin
         if (i == 13) req_valid = 1'b0;
         if (req_valid && req_ready) accepts++;
         if (resp_last && req_ready) ready_when_last++;
         if (resp_valid) begin
            hold_beats++;
            check_eq("hold_rdata", 32'(resp_rdata), 32'hBEEF);
         end
         @(negedge clk);
      end
      check_eq("hold_accepts", 32'(accepts), 32'd3);
      check_eq("hold_beats", 32'(hold_beats), 32'd3);
      check_eq("hold_ready_on_last", 32'(ready_when_last), 32'd0);

      // Burst flag on a write is a single write.
      xact(1'b1, 1'b0, 16'h0000, 16'h0A0A);
      xact(1'b1, 1'b0, 16'h0002, 16'h0B0B);
      xact(1'b1, 1'b0, 16'h0004, 16'h0C0C);
      xact(1'b1, 1'b1, 16'h0002, 16'h1234);
      check_eq("bwr_beats", 32'(n_beats), 32'd1);
      check_eq("bwr_rdata", 32'(beats[0]), 32'd0);
      check_eq("bwr_last", 32'(lasts[0]), 32'd1);
      xact(1'b0, 1'b1, 16'h0000, 16'h0000);
      check_eq("bwr_word0", 32'(beats[0]), 32'h0A0A);
      check_eq("bwr_word1", 32'(beats[1]), 32'h1234);
      check_eq("bwr_word2", 32'(beats[2]), 32'h0C0C);

      // Top-of-memory burst stays inside its block.
      for (int i = 0; i < 7; i++) xact(1'b1, 1'b0, 16'(16'hFFF0 + 2 * i), 16'(16'h7000 + i));
      xact(1'b1, 1'b0, 16'hFFFE, 16'h5555);
      xact(1'b0, 1'b1, 16'hFFFE, 16'h0000);
      check_eq("edge_beats", 32'(n_beats), 32'd8);
      check_eq("edge_first", 32'(beats[0]), 32'h5555);
      for (int i = 1; i < 8; i++)
         check_eq($sformatf("edge_data_%0d", i), 32'(beats[i]), 32'(16'h7000 + i - 1));
      xact(1'b0, 1'b0, 16'h0000, 16'h0000);
      check_eq("edge_word0_intact", 32'(beats[0]), 32'h0A0A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
